// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT types, twiddle scale, complex field helpers and clog2
package fft_pkg;
  typedef enum logic {FILL, ISSUE} state_t;
  localparam int CW = 32;
  localparam int HW = CW / 2;
  localparam int TWID_ONE = 1 << (HW - 2);
  function automatic int twid_one(input int width);
    return 1 << (width / 2 - 2);
  endfunction
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic logic signed [HW-1:0] c_re(input logic [CW-1:0] x);
    return x[CW-1:HW];
  endfunction
  function automatic logic signed [HW-1:0] c_im(input logic [CW-1:0] x);
    return x[HW-1:0];
  endfunction
  function automatic logic [CW-1:0] c_pack(input logic signed [HW-1:0] re, input logic signed [HW-1:0] im);
    return {re, im};
  endfunction
endpackage

// File: rtl/butterfly_feeder_if.sv
// butterfly_feeder_if: sample input stream plus butterfly-side pair outputs
interface butterfly_feeder_if #(parameter int WIDTH = 32, parameter int MWIDTH = 1);
  logic [WIDTH-1:0] in_data;
  logic in_nd;
  logic [MWIDTH-1:0] in_m;
  logic in_ready;
  logic [WIDTH-1:0] xa;
  logic [WIDTH-1:0] xb;
  logic [WIDTH-1:0] w;
  logic x_nd;
  logic [MWIDTH-1:0] m_out;
  logic error;
  modport slave (input in_data, in_nd, in_m, output in_ready, xa, xb, w, x_nd, m_out, error);
  modport master (output in_data, in_nd, in_m, input in_ready, xa, xb, w, x_nd, m_out, error);
endinterface

// File: rtl/butterfly_feeder_twiddle_rom.sv
// twiddle_rom: N/2-entry combinational W_N^k table (k -> w), built at elaboration
module twiddle_rom import fft_pkg::*; #(
  parameter int N = 8,
  parameter int WIDTH = 32
) (
  input  logic [clog2(N/2)-1:0] k,
  output logic [WIDTH-1:0]      w
);
  localparam int H = WIDTH / 2;
  localparam real ONE = real'(twid_one(WIDTH));
  logic [WIDTH-1:0] rom [N/2];
  for (genvar i = 0; i < N / 2; i++) begin : g
    localparam real A = 6.283185307179586 * i / N;
    localparam int RE = int'(ONE * $cos(A));
    localparam int IM = int'(-ONE * $sin(A));
    assign rom[i] = {RE[H-1:0], IM[H-1:0]};
  end
  assign w = rom[k];
endmodule

// File: rtl/butterfly_feeder.sv
// butterfly_feeder: buffers one N-sample frame (E then O) and issues final-stage radix-2 pairs, one every two cycles; ports clk, rst_n, bus (slave)
module butterfly_feeder import fft_pkg::*; #(
  parameter int N = 8,
  parameter int LOG_N = 3,
  parameter int WIDTH = 32,
  parameter int MWIDTH = 1
) (
  input logic clk,
  input logic rst_n,
  butterfly_feeder_if.slave bus
);
  localparam int KW = LOG_N - 1;
  state_t state_q, state_d;
  logic [LOG_N-1:0] wr_cnt_q, wr_cnt_d;
  logic [KW-1:0] k_q, k_d;
  logic ph_q, ph_d, x_nd_q, x_nd_d, err_q, err_d;
  logic [MWIDTH-1:0] tag_q, tag_d, m_q, m_d;
  logic [WIDTH-1:0] xa_q, xa_d, xb_q, xb_d, w_q, w_d, w_rom;
  logic [WIDTH-1:0] mem_q [N];
  logic acc, last;
  twiddle_rom #(.N(N), .WIDTH(WIDTH)) u_rom (.k(k_q), .w(w_rom));
  assign acc = bus.in_nd && state_q == FILL;
  assign last = acc && wr_cnt_q == LOG_N'(N - 1);
  // Pair 0 never needs the final sample, so it goes out on the same edge that
  // accepts it; ph_q=1 then means "next edge is the idle half of pair k".
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    ph_d = ph_q;
    wr_cnt_d = acc ? wr_cnt_q + 1'b1 : wr_cnt_q;
    tag_d = (acc && wr_cnt_q == '0) ? bus.in_m : tag_q;
    x_nd_d = last || (state_q == ISSUE && !ph_q);
    err_d = bus.in_nd && state_q == ISSUE;
    xa_d = x_nd_d ? mem_q[{1'b0, k_q}] : xa_q;
    xb_d = x_nd_d ? mem_q[{1'b1, k_q}] : xb_q;
    w_d = x_nd_d ? w_rom : w_q;
    m_d = x_nd_d ? tag_q : m_q;
    if (last) begin
      state_d = ISSUE;
      ph_d = 1'b1;
    end else if (state_q == ISSUE) begin
      ph_d = !ph_q;
      if (ph_q) begin
        k_d = k_q + 1'b1;
        state_d = k_q == KW'(N / 2 - 1) ? FILL : ISSUE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      wr_cnt_q <= '0;
      k_q <= '0;
      ph_q <= 1'b0;
      tag_q <= '0;
      x_nd_q <= 1'b0;
      err_q <= 1'b0;
      xa_q <= '0;
      xb_q <= '0;
      w_q <= '0;
      m_q <= '0;
    end else begin
      state_q <= state_d;
      wr_cnt_q <= wr_cnt_d;
      k_q <= k_d;
      ph_q <= ph_d;
      tag_q <= tag_d;
      x_nd_q <= x_nd_d;
      err_q <= err_d;
      xa_q <= xa_d;
      xb_q <= xb_d;
      w_q <= w_d;
      m_q <= m_d;
    end
  end
  always_ff @(posedge clk) if (rst_n && acc) mem_q[wr_cnt_q] <= bus.in_data;
  assign bus.in_ready = state_q == FILL;
  assign bus.xa = xa_q;
  assign bus.xb = xb_q;
  assign bus.w = w_q;
  assign bus.x_nd = x_nd_q;
  assign bus.m_out = m_q;
  assign bus.error = err_q;
endmodule

// File: tb/tb_butterfly_feeder.sv
// tb_butterfly_feeder: scoreboard bench for butterfly_feeder (N=8, WIDTH=32)
module tb_butterfly_feeder;
  typedef struct {
    logic [31:0] xa;
    logic [31:0] xb;
    logic [31:0] w;
    logic m;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic prev_nd = 1'b0;
  exp_t exp_q[$];
  logic [31:0] tw [4] = '{32'h40000000, 32'h2D41D2BF, 32'h0000C000, 32'hD2BFD2BF};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  butterfly_feeder_if #(.WIDTH(32), .MWIDTH(1)) bus ();
  butterfly_feeder #(.N(8), .LOG_N(3), .WIDTH(32), .MWIDTH(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.x_nd === 1'b1) begin
      chk("x_nd_spacing", 64'(prev_nd), 64'd0);
      if (exp_q.size() == 0) chk("unexpected_pair", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("xa", 64'(bus.xa), 64'(e.xa));
        chk("xb", 64'(bus.xb), 64'(e.xb));
        chk("w", 64'(bus.w), 64'(e.w));
        chk("m_out", 64'(bus.m_out), 64'(e.m));
        chk("pair_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    prev_nd = bus.x_nd === 1'b1;
  end

  task automatic send(input logic [31:0] d, input logic m, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.in_data = d;
    bus.in_m = m;
    bus.in_nd = 1'b1;
    @(posedge clk);
    #1;
    bus.in_nd = 1'b0;
  endtask

  task automatic frame(input logic [31:0] d [8], input logic m, input int gap, output int c0);
    for (int i = 0; i < 8; i++) send(d[i], m, gap);
    c0 = cyc;
    for (int k = 0; k < 4; k++) exp_q.push_back('{d[k], d[k+4], tw[k], m, c0 + 2 * k});
    chk("ready_drop", 64'(bus.in_ready), 64'd0);
  endtask

  task automatic wait_ready(input int c0);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_rise_cycle", 64'(cyc), 64'(c0 + 7));
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_x_nd", 64'(bus.x_nd), 64'd0);
    chk("rst_error", 64'(bus.error), 64'd0);
    chk("rst_xa", 64'(bus.xa), 64'd0);
    chk("rst_xb", 64'(bus.xb), 64'd0);
    chk("rst_w", 64'(bus.w), 64'd0);
    chk("rst_m_out", 64'(bus.m_out), 64'd0);
  endtask

  initial begin
    logic [31:0] d [8];
    int c0;
    bus.in_nd = 1'b0;
    bus.in_data = '0;
    bus.in_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) d[i] = 32'(i);
    frame(d, 1'b1, 0, c0);
    wait_ready(c0);
    for (int i = 0; i < 8; i++) d[i] = 32'hA0000000 + 32'(i);
    frame(d, 1'b0, 2, c0);
    wait_ready(c0);
    for (int i = 0; i < 8; i++) d[i] = 32'h00005500 + 32'(i);
    frame(d, 1'b1, 0, c0);
    bus.in_data = 32'hDEADBEEF;
    bus.in_nd = 1'b1;
    @(posedge clk);
    #1;
    bus.in_nd = 1'b0;
    chk("error_pulse", 64'(bus.error), 64'd1);
    @(posedge clk);
    #1;
    chk("error_clear", 64'(bus.error), 64'd0);
    wait_ready(c0);
    for (int i = 0; i < 8; i++) d[i] = 32'h77000000 + 32'(i);
    frame(d, 1'b0, 0, c0);
    wait_ready(c0);
    for (int i = 0; i < 8; i++) d[i] = 32'h99000000 + 32'(i);
    frame(d, 1'b1, 0, c0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    chk_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) send(32'hBAD00000 + 32'(i), 1'b1, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) d[i] = 32'h000000C0 + 32'(i);
    frame(d, 1'b0, 0, c0);
    wait_ready(c0);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) d[i] = $urandom;
      frame(d, f[0], 0, c0);
      wait_ready(c0);
    end
    repeat (12) @(posedge clk);
    #1;
    chk("pairs_outstanding", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
